// File: rtl/fraction_align_shifter_pkg.sv
// Shared floating-point adder constants and the alignment FSM state encoding.
// Imported by the alignment stage and its shift-step sub-module.
package fp_add_pkg;

  localparam int FRAC_W  = 24;
  localparam int EXP_W   = 8;
  localparam int GRS_W   = 3;
  localparam int ALIGN_W = FRAC_W + GRS_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;

endpackage

// File: rtl/fraction_align_shifter_if.sv
// Operand/result handshake bundle between fraction select, alignment and add/sub stages.
// The master side drives operands and consumes results; the slave side is the alignment stage.
interface fraction_align_shifter_if #(
  parameter int FRAC_W = 24,
  parameter int EXP_W  = 8
);

  logic                in_valid;
  logic                in_ready;
  logic [FRAC_W-1:0]   in_frac;
  logic [EXP_W-1:0]    in_diff;
  logic [EXP_W-1:0]    in_exp;
  logic                out_valid;
  logic                out_ready;
  logic [FRAC_W+2:0]   out_frac;
  logic [EXP_W-1:0]    out_exp;

  modport master (
    output in_valid, in_frac, in_diff, in_exp, out_ready,
    input  in_ready, out_valid, out_frac, out_exp
  );

  modport slave (
    input  in_valid, in_frac, in_diff, in_exp, out_ready,
    output in_ready, out_valid, out_frac, out_exp
  );

endinterface

// File: rtl/fraction_align_shifter_step.sv
// Combinational right shift by n <= STEP bits; with FRAC_ALIGN_STICKY_EN defined the
// dropped bits are OR-ed into bit0, otherwise they are simply truncated.
module sticky_shift_step #(
  parameter int W    = 27,
  parameter int STEP = 4
) (
  input  logic [W-1:0]               i_data,
  input  logic [$clog2(STEP+1)-1:0]  i_n,
  output logic [W-1:0]               o_data
);

  logic [W-1:0] w_shift;

  assign w_shift = i_data >> i_n;

`ifdef FRAC_ALIGN_STICKY_EN
  logic w_lost;

  // OR-reduce the low i_n bits that fall off the right end
  always_comb begin
    w_lost = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      w_lost = w_lost | (i_data[i] & (i < int'(i_n)));
    end
  end

  assign o_data = {w_shift[W-1:1], w_shift[0] | w_lost};
`else
  assign o_data = w_shift;
`endif

endmodule

// File: rtl/fraction_align_shifter.sv
// FP adder alignment stage: iteratively right-shifts the smaller fraction by the exponent
// difference, STEP bits per cycle, keeping G/R/S bits. Sticky OR enabled by FRAC_ALIGN_STICKY_EN.
module fraction_align_shifter
  import fp_add_pkg::*;
#(
  parameter int FRAC_W = 24,
  parameter int EXP_W  = 8,
  parameter int STEP   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fraction_align_shifter_if.slave bus
);

  localparam int AW    = FRAC_W + GRS_W;
  localparam int REM_W = $clog2(AW + 1);
  localparam int N_W   = $clog2(STEP + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [AW-1:0]    r_work;
  logic [AW-1:0]    w_shifted;
  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] w_init_rem;
  logic [N_W-1:0]   w_n;
  logic [EXP_W-1:0] r_exp;
  logic             w_accept;

  assign w_accept      = r_in_ready & bus.in_valid;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_frac  = r_work;
  assign bus.out_exp   = r_exp;

  sticky_shift_step #(
    .W    (AW),
    .STEP (STEP)
  ) u_step (
    .i_data (r_work),
    .i_n    (w_n),
    .o_data (w_shifted)
  );

  // Shift-amount clamping, per-cycle step size and next-state decode
  always_comb begin
    w_init_rem   = REM_W'(bus.in_diff);
    w_n          = N_W'(r_rem);
    w_next_state = r_state;

    if (int'(bus.in_diff) >= AW) begin
      w_init_rem = REM_W'(AW);
    end else begin
      w_init_rem = REM_W'(bus.in_diff);
    end

    if (int'(r_rem) > STEP) begin
      w_n = N_W'(STEP);
    end else begin
      w_n = N_W'(r_rem);
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (w_init_rem != {REM_W{1'b0}}) ? S_SHIFT : S_DONE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_rem == REM_W'(w_n)) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, registered handshake outputs and the shifting datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_work      <= {AW{1'b0}};
      r_rem       <= {REM_W{1'b0}};
      r_exp       <= {EXP_W{1'b0}};
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_work <= {bus.in_frac, {GRS_W{1'b0}}};
            r_exp  <= bus.in_exp;
            r_rem  <= w_init_rem;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= r_rem - REM_W'(w_n);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fraction_align_shifter.sv
// Directed and randomised bench for fraction_align_shifter with STEP = 1, 4 and 27.
// Expected results follow FRAC_ALIGN_STICKY_EN the same way the design does.
module tb_fraction_align_shifter;

`ifdef FRAC_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  fraction_align_shifter_if #(.FRAC_W(24), .EXP_W(8)) if1 ();
  fraction_align_shifter_if #(.FRAC_W(24), .EXP_W(8)) if4 ();
  fraction_align_shifter_if #(.FRAC_W(24), .EXP_W(8)) if27 ();

  fraction_align_shifter #(.FRAC_W(24), .EXP_W(8), .STEP(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  fraction_align_shifter #(.FRAC_W(24), .EXP_W(8), .STEP(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  fraction_align_shifter #(.FRAC_W(24), .EXP_W(8), .STEP(27)) u_dut27 (.clk(clk), .rst_n(rst_n), .bus(if27));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL global_timeout: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Independent reference: one-shot shift plus OR of every dropped bit
  function automatic logic [26:0] ref_align(input logic [23:0] f, input int dd);
    logic [26:0] w;
    logic [26:0] r;
    logic [31:0] mask;
    w    = {f, 3'b000};
    r    = w >> dd;
    mask = (32'd1 << dd) - 32'd1;
    if (STICKY) r[0] = r[0] | (|(w & mask[26:0]));
    return r;
  endfunction

  function automatic int ref_lat(input int dd, input int step);
    return (dd == 0) ? 1 : 1 + (dd + step - 1) / step;
  endfunction

  task automatic op4(input string tag, input logic [23:0] f, input logic [7:0] d,
                     input logic [7:0] e, input int lat_exp, input logic [26:0] fr_exp);
    int k;
    int lat;
    k = 0;
    while (!if4.in_ready && k < 50) begin
      tick();
      k++;
    end
    if4.in_frac  = f;
    if4.in_diff  = d;
    if4.in_exp   = e;
    if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    lat = 1;
    while (!if4.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, lat_exp);
    chk({tag, "_frac"}, if4.out_frac, fr_exp);
    chk({tag, "_exp"}, if4.out_exp, e);
    tick();
  endtask

  initial begin
    logic [23:0] f;
    logic [7:0]  d;
    int          dd;
    int          k;
    int          lat;
    int          c;
    int          l1, l4, l27;
    logic [26:0] f1, f4, f27;
    logic [26:0] exp_f;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    if1.in_valid = 1'b0;  if1.out_ready = 1'b1;  if1.in_frac = 24'h0;  if1.in_diff = 8'h0;  if1.in_exp = 8'h0;
    if4.in_valid = 1'b0;  if4.out_ready = 1'b1;  if4.in_frac = 24'h0;  if4.in_diff = 8'h0;  if4.in_exp = 8'h0;
    if27.in_valid = 1'b0; if27.out_ready = 1'b1; if27.in_frac = 24'h0; if27.in_diff = 8'h0; if27.in_exp = 8'h0;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", if4.in_ready, 0);
    chk("rst_out_valid", if4.out_valid, 0);
    chk("rst_out_frac", if4.out_frac, 0);
    chk("rst_out_exp", if4.out_exp, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", if4.in_ready, 1);

    // Directed vectors on the STEP=4 instance
    op4("d0", 24'h800000, 8'd0, 8'h85, 1, 27'h4000000);
    op4("d5", 24'h800001, 8'd5, 8'h33, 3, STICKY ? 27'h0200001 : 27'h0200000);
    op4("d40", 24'h000001, 8'd40, 8'h7f, 8, STICKY ? 27'h0000001 : 27'h0000000);
    op4("d40z", 24'h000000, 8'd40, 8'h01, 8, 27'h0000000);
    op4("d27", 24'hffffff, 8'd27, 8'h10, 8, STICKY ? 27'h0000001 : 27'h0000000);
    op4("d26", 24'h800000, 8'd26, 8'h20, 8, 27'h0000001);

    // Backpressure: result held, second operand waits
    if4.out_ready = 1'b0;
    if4.in_frac = 24'h800000; if4.in_diff = 8'd4; if4.in_exp = 8'h12; if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    lat = 1;
    while (!if4.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp_lat", lat, 2);
    if4.in_frac = 24'habcdef; if4.in_diff = 8'd0; if4.in_exp = 8'h44; if4.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", if4.out_valid, 1);
      chk("bp_hold_frac", if4.out_frac, 27'h0400000);
      chk("bp_hold_exp", if4.out_exp, 8'h12);
      chk("bp_hold_in_ready", if4.in_ready, 0);
      tick();
    end
    if4.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", if4.out_valid, 0);
    chk("bp_release_ready", if4.in_ready, 1);
    tick();
    if4.in_valid = 1'b0;
    chk("bp_second_valid", if4.out_valid, 1);
    chk("bp_second_frac", if4.out_frac, 27'h55e6f78);
    chk("bp_second_exp", if4.out_exp, 8'h44);
    tick();

    // Reset asserted during SHIFT aborts at once
    if4.in_frac = 24'hffffff; if4.in_diff = 8'd27; if4.in_exp = 8'h55; if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", if4.out_valid, 0);
    chk("mid_rst_ready", if4.in_ready, 0);
    chk("mid_rst_frac", if4.out_frac, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_idle", if4.in_ready, 1);
    repeat (9) tick();
    chk("mid_rst_no_result", if4.out_valid, 0);

    // Random sweep on all three step sizes at once
    for (k = 0; k < 1000; k++) begin
      f = ($urandom_range(0, 9) == 0) ? 24'h0 : 24'($urandom);
      d = (k % 50 == 0) ? 8'hff : 8'($urandom_range(0, 40));
      dd = (int'(d) > 27) ? 27 : int'(d);
      exp_f = ref_align(f, dd);
      if1.in_frac = f;  if1.in_diff = d;  if1.in_exp = 8'(k);  if1.in_valid = 1'b1;
      if4.in_frac = f;  if4.in_diff = d;  if4.in_exp = 8'(k);  if4.in_valid = 1'b1;
      if27.in_frac = f; if27.in_diff = d; if27.in_exp = 8'(k); if27.in_valid = 1'b1;
      tick();
      if1.in_valid = 1'b0; if4.in_valid = 1'b0; if27.in_valid = 1'b0;
      l1 = 0; l4 = 0; l27 = 0;
      f1 = 27'h0; f4 = 27'h0; f27 = 27'h0;
      c = 1;
      while (1) begin
        if (l1 == 0 && if1.out_valid) begin l1 = c; f1 = if1.out_frac; end
        if (l4 == 0 && if4.out_valid) begin l4 = c; f4 = if4.out_frac; end
        if (l27 == 0 && if27.out_valid) begin l27 = c; f27 = if27.out_frac; end
        if ((l1 != 0 && l4 != 0 && l27 != 0) || c >= 40) break;
        tick();
        c++;
      end
      chk("rnd_s1_lat", l1, ref_lat(dd, 1));
      chk("rnd_s1_frac", f1, exp_f);
      chk("rnd_s4_lat", l4, ref_lat(dd, 4));
      chk("rnd_s4_frac", f4, exp_f);
      chk("rnd_s27_lat", l27, ref_lat(dd, 27));
      chk("rnd_s27_frac", f27, exp_f);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
